// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared definitions for the MEM pipeline stage:
//   - bus typedefs (MemOpBus, RegAddrBus, RegBus, ByteBus)
//   - memory op codes MEMOP_*
//   - pipeline constants (NOPRegAddr, ZeroWord, WriteDisable, RstEnable, PauseDisable)
//   - FSM state encoding for the byte-serial access engine
//   - helpers that decode an op into its byte count and direction
package mem_stage_pkg;

  typedef logic [3:0]  MemOpBus;
  typedef logic [4:0]  RegAddrBus;
  typedef logic [31:0] RegBus;
  typedef logic [7:0]  ByteBus;

  localparam MemOpBus MEMOP_NOP = 4'd0;
  localparam MemOpBus MEMOP_LB  = 4'd1;
  localparam MemOpBus MEMOP_LH  = 4'd2;
  localparam MemOpBus MEMOP_LW  = 4'd3;
  localparam MemOpBus MEMOP_LBU = 4'd4;
  localparam MemOpBus MEMOP_LHU = 4'd5;
  localparam MemOpBus MEMOP_SB  = 4'd6;
  localparam MemOpBus MEMOP_SH  = 4'd7;
  localparam MemOpBus MEMOP_SW  = 4'd8;

  localparam RegAddrBus NOPRegAddr   = 5'd0;
  localparam RegBus     ZeroWord     = 32'd0;
  localparam logic      WriteDisable = 1'b0;
  localparam logic      RstEnable    = 1'b1;
  localparam logic      PauseDisable = 1'b0;

  typedef enum logic [1:0] {
    MEMST_IDLE   = 2'd0,
    MEMST_ACCESS = 2'd1,
    MEMST_DONE   = 2'd2
  } memst_e;

  // Number of byte transfers an op needs; 0 means "not a memory op",
  // which also covers every undefined code.
  function automatic logic [2:0] memop_bytes(input MemOpBus op);
    case (op)
      MEMOP_LB, MEMOP_LBU, MEMOP_SB: memop_bytes = 3'd1;
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: memop_bytes = 3'd2;
      MEMOP_LW, MEMOP_SW:            memop_bytes = 3'd4;
      default:                       memop_bytes = 3'd0;
    endcase
  endfunction

  function automatic logic memop_is_store(input MemOpBus op);
    memop_is_store = (op == MEMOP_SB) || (op == MEMOP_SH) || (op == MEMOP_SW);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if
// Byte-wide memory-controller port used by the MEM stage.
//   req   : byte access request (master -> slave)
//   we    : 1 = write, 0 = read
//   addr  : byte address
//   wdata : write byte
//   ack   : byte access complete; read byte valid this cycle (slave -> master)
//   rdata : read byte
interface mem_stage_if #(
  parameter int ADDR_W = 32
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;
  logic              ack;
  logic [7:0]        rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/mem_load_ext.sv
// mem_load_ext
// Combinational load-data extension. Takes the assembled little-endian
// buffer and the load op, and returns the 32-bit writeback word.
//   op_i   : load op code (MEMOP_*)
//   buf_i  : assembled byte buffer, lane 0 = lowest address
//   data_o : sign/zero-extended writeback word
// Lanes above the op's width are don't-care and get masked here.
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  MemOpBus     op_i,
  input  logic [31:0] buf_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = buf_i;
    case (op_i)
      MEMOP_LB:  data_o = {{24{buf_i[7]}}, buf_i[7:0]};
      MEMOP_LBU: data_o = {24'd0, buf_i[7:0]};
      MEMOP_LH:  data_o = {{16{buf_i[15]}}, buf_i[15:0]};
      MEMOP_LHU: data_o = {16'd0, buf_i[15:0]};
      default:   data_o = buf_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
// MEM pipeline stage. Passes non-memory ops straight through to MEM/WB and
// runs loads/stores as byte-serial transfers on an 8-bit controller port,
// stalling the pipeline until the access completes.
//   clk, rst       : clock, synchronous active-high reset
//   rdy            : global ready; 0 freezes all state
//   ex_*           : EX/MEM register outputs (wd, wreg, wdata, memop, memaddr, storedata)
//   mem_wd_o/mem_wreg_o/mem_wdata_o : to MEM/WB register
//   stall_req_o    : stall request to pipeline control
//   mc             : byte-wide memory-controller port (master side)
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [REG_ADDR_W-1:0] ex_wd_i,
  input  logic                  ex_wreg_i,
  input  logic [DATA_W-1:0]     ex_wdata_i,
  input  MemOpBus               ex_memop_i,
  input  logic [ADDR_W-1:0]     ex_memaddr_i,
  input  logic [DATA_W-1:0]     ex_storedata_i,
  output logic [REG_ADDR_W-1:0] mem_wd_o,
  output logic                  mem_wreg_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  output logic                  stall_req_o,
  mem_stage_if.master           mc
);

  memst_e                  state_q, state_d;
  logic [1:0]              cnt_q;
  logic [1:0]              cnt_nxt;
  MemOpBus                 op_q;
  logic [ADDR_W-1:0]       base_q;
  logic [DATA_W-1:0]       sdata_q;
  logic [DATA_W-1:0]       alu_q;
  logic [REG_ADDR_W-1:0]   wd_q;
  logic                    wreg_q;
  logic [31:0]             buf_q;
  logic [31:0]             load_word;
  logic                    ex_is_mem;
  logic                    last_byte;
  logic                    ack_fire;

  assign ex_is_mem = (memop_bytes(ex_memop_i) != 3'd0);
  assign last_byte = ({1'b0, cnt_q} == (memop_bytes(op_q) - 3'd1));
  assign cnt_nxt   = cnt_q + 2'd1;
  // An ack only counts while a request is actually outstanding.
  assign ack_fire  = mc.req && mc.ack;

  mem_load_ext u_load_ext (
    .op_i   (op_q),
    .buf_i  (buf_q),
    .data_o (load_word)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= MEMST_IDLE;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  // Next state plus the combinational MEM/WB and stall outputs. DONE always
  // returns to IDLE without looking at EX/MEM, which still holds the op that
  // was just served.
  always_comb begin
    state_d     = state_q;
    mem_wd_o    = REG_ADDR_W'(NOPRegAddr);
    mem_wreg_o  = WriteDisable;
    mem_wdata_o = DATA_W'(ZeroWord);
    stall_req_o = PauseDisable;
    if (rst != RstEnable) begin
      case (state_q)
        MEMST_IDLE: begin
          if (ex_is_mem) begin
            stall_req_o = 1'b1;
            state_d     = MEMST_ACCESS;
          end else begin
            mem_wd_o    = ex_wd_i;
            mem_wreg_o  = ex_wreg_i;
            mem_wdata_o = ex_wdata_i;
          end
        end
        MEMST_ACCESS: begin
          stall_req_o = 1'b1;
          if (ack_fire && last_byte) begin
            state_d = MEMST_DONE;
          end
        end
        MEMST_DONE: begin
          mem_wd_o    = wd_q;
          mem_wreg_o  = wreg_q;
          mem_wdata_o = memop_is_store(op_q) ? alu_q : DATA_W'(load_word);
          state_d     = MEMST_IDLE;
        end
        default: state_d = MEMST_IDLE;
      endcase
    end
  end

  // Transaction datapath: latches the op on launch, then steps the byte
  // counter on each accepted ack. Address and store byte are registered so
  // they stay stable across controller wait states.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      cnt_q    <= 2'd0;
      buf_q    <= 32'd0;
      op_q     <= MEMOP_NOP;
      base_q   <= '0;
      sdata_q  <= '0;
      alu_q    <= '0;
      wd_q     <= '0;
      wreg_q   <= 1'b0;
      mc.req   <= 1'b0;
      mc.we    <= 1'b0;
      mc.addr  <= '0;
      mc.wdata <= 8'd0;
    end else if (rdy) begin
      case (state_q)
        MEMST_IDLE: begin
          if (ex_is_mem) begin
            op_q     <= ex_memop_i;
            base_q   <= ex_memaddr_i;
            sdata_q  <= ex_storedata_i;
            alu_q    <= ex_wdata_i;
            wd_q     <= ex_wd_i;
            wreg_q   <= ex_wreg_i;
            cnt_q    <= 2'd0;
            mc.req   <= 1'b1;
            mc.we    <= memop_is_store(ex_memop_i);
            mc.addr  <= ex_memaddr_i;
            mc.wdata <= ex_storedata_i[7:0];
          end
        end
        MEMST_ACCESS: begin
          if (ack_fire) begin
            if (!memop_is_store(op_q)) begin
              buf_q[{cnt_q, 3'b000} +: 8] <= mc.rdata;
            end
            if (last_byte) begin
              mc.req <= 1'b0;
            end else begin
              cnt_q    <= cnt_nxt;
              // Misaligned and wrapping addresses are legal, so this is a
              // plain modular add with no alignment check.
              mc.addr  <= base_q + ADDR_W'(cnt_nxt);
              mc.wdata <= sdata_q[{cnt_nxt, 3'b000} +: 8];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
